// File: rtl/fifo_drain_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_tx
// Description : Drains a fixed number of result words from a FIFO and
//               serialises each word to a byte sink, most significant byte
//               first, using a valid/ready handshake.
// Ports       : clk, nrst           - clock, synchronous active-low reset
//               start               - run request (seen in IDLE/DONE only)
//               fifo_empty/rd_en    - FIFO status and read strobe
//               fifo_dout           - FIFO data, valid the cycle after rd_en
//               tx_valid/ready/data - byte sink handshake
//               busy, done          - run status
//               words_sent          - words fully sent in the current run
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_tx #(
    parameter int data_width_out = 40,
    parameter int num_words      = 4096,
    parameter int cnt_bits       = 13
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      start,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [data_width_out-1:0] fifo_dout,
    input  logic                      tx_ready,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    output logic                      busy,
    output logic                      done,
    output logic [cnt_bits-1:0]       words_sent
);

    localparam int                  c_bytes     = data_width_out / 8;
    localparam int                  c_idx_w     = (c_bytes > 1) ? $clog2(c_bytes) : 1;
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(c_bytes - 1);
    localparam logic [cnt_bits-1:0] c_num_words = cnt_bits'(num_words);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RD    = 3'd2,
        S_LATCH = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [data_width_out-1:0] shift_q, shift_d;
    logic [c_idx_w-1:0]        idx_q,   idx_d;
    logic [cnt_bits-1:0]       cnt_q,   cnt_d;
    logic [cnt_bits-1:0]       cnt_inc;

    assign cnt_inc = cnt_q + cnt_bits'(1);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (!fifo_empty) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // Read decision was made in WAIT; data arrives next cycle.
                fifo_rd_en = 1'b1;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                shift_d = fifo_dout;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[data_width_out-1 -: 8];
                if (tx_ready) begin
                    shift_d = shift_q << 8;
                    idx_d   = idx_q + c_idx_w'(1);
                    if (idx_q == c_last_idx) begin
                        // Counter stops at num_words because the run ends here.
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == c_num_words) ? S_DONE : S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign words_sent = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_tx
// Description : Self-checking bench for fifo_drain_tx with a behavioural FIFO,
//               a byte sink recorder and a word-to-byte reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_tx;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [39:0] fifo_dout = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic [12:0] words_sent;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural FIFO
    logic [39:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_count = 0;
    int          underflow = 0;
    bit          force_empty = 1'b0;

    // Byte sink recorder
    logic [7:0]  rx_mem [1024];
    int          rx_cyc [1024];
    int          rx_cnt = 0;
    int          cyc = 0;

    // Reference: bytes of these words in MSB-first order
    logic [39:0] exp_words [$];

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    fifo_drain_tx #(
        .data_width_out(40),
        .num_words     (2),
        .cnt_bits      (13)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            fifo_dout <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end
        if (nrst && tx_valid && tx_ready) begin
            rx_mem[rx_cnt % 1024] <= tx_data;
            rx_cyc[rx_cnt % 1024] <= cyc;
            rx_cnt                <= rx_cnt + 1;
        end
    end

    function automatic logic [7:0] exp_byte(input int k);
        logic [39:0] w;
        w = exp_words[k / 5];
        return w[8 * (4 - (k % 5)) +: 8];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [39:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        start = 1'b0;
        tx_ready = 1'b0;
        force_empty = 1'b0;
        tick(2);
        flush();
        nrst = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        int i;
        i = 0;
        while (!done && i < max) begin
            tick(1);
            i++;
        end
        ok = done;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int rd0;
        nrst = 1'b0;
        start = 1'b1;
        tx_ready = 1'b1;
        push_word(40'h1111111111);
        rd0 = rd_count;
        tick(3);
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_chk++; if (words_sent !== 13'd0) begin n_fail++; $display("FAIL reset_words_sent got %0d want 0", words_sent); end
        start = 1'b0;
        nrst = 1'b1;
        tick(5);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
        n_chk++; if (rd_count - rd0 !== 0) begin n_fail++; $display("FAIL reset_idle_reads got %0d want 0", rd_count - rd0); end
        flush();
    endtask

    task automatic test_basic();
        int base, rd0;
        bit ok;
        apply_reset();
        push_word(40'h0123456789);
        push_word(40'hA1B2C3D4E5);
        exp_words = {40'h0123456789, 40'hA1B2C3D4E5};
        tx_ready = 1'b1;
        base = rx_cnt;
        rd0 = rd_count;
        pulse_start();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(100, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout got %b want 1", done); end
        n_chk++; if (rx_cnt - base !== 10) begin n_fail++; $display("FAIL basic_byte_count got %0d want 10", rx_cnt - base); end
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                n_fail++; $display("FAIL basic_byte[%0d] got %h want %h", k, rx_mem[(base + k) % 1024], exp_byte(k));
            end
        end
        n_chk++; if (rd_count - rd0 !== 2) begin n_fail++; $display("FAIL basic_reads got %0d want 2", rd_count - rd0); end
        n_chk++; if (words_sent !== 13'd2) begin n_fail++; $display("FAIL basic_words_sent got %0d want 2", words_sent); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy got %b want 0", busy); end
        n_chk++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL basic_done_tx got %b/%h want 0/00", tx_valid, tx_data); end
        tick(3);
        n_chk++; if (done !== 1'b1 || words_sent !== 13'd2) begin n_fail++; $display("FAIL basic_done_hold got %b/%0d want 1/2", done, words_sent); end
    endtask

    task automatic test_backpressure();
        int base, n;
        bit ok;
        apply_reset();
        push_word(40'h0123456789);
        push_word(40'hA1B2C3D4E5);
        exp_words = {40'h0123456789, 40'hA1B2C3D4E5};
        tx_ready = 1'b1;
        base = rx_cnt;
        pulse_start();
        n = 0;
        while (!(tx_valid && tx_data == 8'h45) && n < 50) begin tick(1); n++; end
        n_chk++; if (n >= 50) begin n_fail++; $display("FAIL bp_find45 got %h want 45", tx_data); end
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
                n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/45", i, tx_valid, tx_data);
            end
            tick(1);
        end
        tx_ready = 1'b1;
        wait_done(100, ok);
        n_chk++; if (!ok || rx_cnt - base !== 10) begin n_fail++; $display("FAIL bp_count got %0d want 10", rx_cnt - base); end
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                n_fail++; $display("FAIL bp_byte[%0d] got %h want %h", k, rx_mem[(base + k) % 1024], exp_byte(k));
            end
        end
    endtask

    task automatic test_empty_wait();
        int base, n;
        bit ok;
        apply_reset();
        force_empty = 1'b1;
        push_word(40'h0123456789);
        push_word(40'hA1B2C3D4E5);
        exp_words = {40'h0123456789, 40'hA1B2C3D4E5};
        tx_ready = 1'b1;
        base = rx_cnt;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (fifo_rd_en !== 1'b0 || tx_valid !== 1'b0) begin
                n_fail++; $display("FAIL empty_idle[%0d] got %b/%b want 0/0", i, fifo_rd_en, tx_valid);
            end
            tick(1);
        end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy got %b want 1", busy); end
        force_empty = 1'b0;
        n = 0;
        while (!tx_valid && n < 10) begin tick(1); n++; end
        n_chk++; if (n !== 3) begin n_fail++; $display("FAIL empty_latency got %0d want 3", n); end
        wait_done(100, ok);
        n_chk++; if (!ok || rx_cnt - base !== 10) begin n_fail++; $display("FAIL empty_count got %0d want 10", rx_cnt - base); end
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                n_fail++; $display("FAIL empty_byte[%0d] got %h want %h", k, rx_mem[(base + k) % 1024], exp_byte(k));
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int base, rd0, n;
        apply_reset();
        push_word(40'h0123456789);
        push_word(40'hA1B2C3D4E5);
        tx_ready = 1'b1;
        base = rx_cnt;
        rd0 = rd_count;
        pulse_start();
        n = 0;
        while (rx_cnt - base < 2 && n < 50) begin tick(1); n++; end
        n_chk++; if (rx_cnt - base !== 2 || tx_data !== 8'h45) begin n_fail++; $display("FAIL rmid_pos got %0d/%h want 2/45", rx_cnt - base, tx_data); end
        nrst = 1'b0;
        tick(1);
        n_chk++; if (fifo_rd_en !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_tx got %b/%b/%h want 0/0/00", fifo_rd_en, tx_valid, tx_data); end
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_status got %b/%b want 0/0", busy, done); end
        n_chk++; if (words_sent !== 13'd0) begin n_fail++; $display("FAIL rmid_words got %0d want 0", words_sent); end
        nrst = 1'b1;
        tick(10);
        n_chk++; if (rx_cnt - base !== 2) begin n_fail++; $display("FAIL rmid_no_tx got %0d want 2", rx_cnt - base); end
        n_chk++; if (rd_count - rd0 !== 1) begin n_fail++; $display("FAIL rmid_reads got %0d want 1", rd_count - rd0); end
        n_chk++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %b/%b want 0/0", busy, tx_valid); end
        flush();
    endtask

    task automatic test_start_handling();
        int base, rd0, n;
        bit ok;
        apply_reset();
        push_word(40'h1020304050);
        push_word(40'h6070809000);
        push_word(40'hDEADBEEF42);
        exp_words = {40'h1020304050, 40'h6070809000, 40'hDEADBEEF42};
        tx_ready = 1'b1;
        base = rx_cnt;
        rd0 = rd_count;
        pulse_start();
        n = 0;
        while (!tx_valid && n < 20) begin tick(1); n++; end
        pulse_start();
        wait_done(100, ok);
        n_chk++; if (!ok || rx_cnt - base !== 10) begin n_fail++; $display("FAIL sti_count got %0d want 10", rx_cnt - base); end
        n_chk++; if (rd_count - rd0 !== 2) begin n_fail++; $display("FAIL sti_reads got %0d want 2", rd_count - rd0); end
        n_chk++; if (words_sent !== 13'd2) begin n_fail++; $display("FAIL sti_words got %0d want 2", words_sent); end
        for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                n_fail++; $display("FAIL sti_byte[%0d] got %h want %h", k, rx_mem[(base + k) % 1024], exp_byte(k));
            end
        end
        pulse_start();
        n_chk++; if (words_sent !== 13'd0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL restart got %0d/%b/%b want 0/1/0", words_sent, busy, done); end
        n = 0;
        while (rx_cnt - base < 15 && n < 50) begin tick(1); n++; end
        for (int k = 10; k < 15; k++) begin
            n_chk++;
            if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                n_fail++; $display("FAIL restart_byte[%0d] got %h want %h", k, rx_mem[(base + k) % 1024], exp_byte(k));
            end
        end
        n_chk++; if (words_sent !== 13'd1 || done !== 1'b0) begin n_fail++; $display("FAIL restart_words got %0d/%b want 1/0", words_sent, done); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        apply_reset();
        push_word(40'hCAFEF00D11);
        push_word(40'h22BADC0DE3);
        tx_ready = 1'b1;
        base = rx_cnt;
        pulse_start();
        wait_done(100, ok);
        n_chk++; if (!ok || rx_cnt - base !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", rx_cnt - base); end
        n_chk++;
        if (rx_cyc[(base + 5) % 1024] - rx_cyc[base % 1024] !== 8) begin
            n_fail++; $display("FAIL b2b_period got %0d want 8", rx_cyc[(base + 5) % 1024] - rx_cyc[base % 1024]);
        end
        n_chk++;
        if (rx_cyc[(base + 4) % 1024] - rx_cyc[base % 1024] !== 4) begin
            n_fail++; $display("FAIL b2b_byte_rate got %0d want 4", rx_cyc[(base + 4) % 1024] - rx_cyc[base % 1024]);
        end
    endtask

    task automatic test_random();
        int base, rd0, n;
        logic [39:0] w;
        logic        pv, pr;
        logic [7:0]  pd;
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            exp_words = {};
            for (int i = 0; i < 2 + (r % 2); i++) begin
                w = {8'($urandom), 32'($urandom)};
                push_word(w);
                exp_words.push_back(w);
            end
            base = rx_cnt;
            rd0 = rd_count;
            pulse_start();
            pv = 1'b0; pr = 1'b0; pd = 8'h00;
            n = 0;
            while (!done && n < 400) begin
                if (pv && !pr) begin
                    n_chk++;
                    if (tx_valid !== 1'b1 || tx_data !== pd) begin
                        n_fail++; $display("FAIL rnd_stall_hold got %b/%h want 1/%h", tx_valid, tx_data, pd);
                    end
                end
                tx_ready = 1'($urandom_range(0, 1));
                force_empty = ($urandom_range(0, 3) == 0);
                pv = tx_valid; pr = tx_ready; pd = tx_data;
                tick(1);
                n++;
            end
            n_chk++; if (!done || rx_cnt - base !== 10) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want 10", r, rx_cnt - base); end
            n_chk++; if (rd_count - rd0 !== 2 || words_sent !== 13'd2) begin n_fail++; $display("FAIL rnd_words[%0d] got %0d/%0d want 2/2", r, rd_count - rd0, words_sent); end
            for (int k = 0; k < 10; k++) begin
                n_chk++;
                if (rx_mem[(base + k) % 1024] !== exp_byte(k)) begin
                    n_fail++; $display("FAIL rnd_byte[%0d][%0d] got %h want %h", r, k, rx_mem[(base + k) % 1024], exp_byte(k));
                end
            end
        end
        force_empty = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1);
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_wait();
        test_reset_mid_word();
        test_start_handling();
        test_back_to_back();
        test_random();
        n_chk++; if (underflow !== 0) begin n_fail++; $display("FAIL underflow got %0d want 0", underflow); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
